fetch_queue: RTL and testbench

Circular instruction buffer between `fetch` and `decode`. It absorbs the fixed four-wide fetch packet and releases a variable number of entries per cycle as `decode` accepts them, so fetch can run ahead while decode is throttled by issue-queue space. It supports flash from the control block on branch redirect.

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/fq_lane_rotate.sv | 49 ++++
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg -- shared sizes and helpers for the fetch-to-decode queue.
//   FETCH_QUEUE_DEPTH : default number of queue entries (power of two, >= 4)
//   FQ_LANES          : push/pop lanes, matching the four-wide decode packet
//   DECODE_REQUIRE_W  : bits per decode_require entry
package fetch_queue_pkg;

  localparam int FETCH_QUEUE_DEPTH = 8;
  localparam int FQ_LANES          = 4;
  localparam int DECODE_REQUIRE_W  = 32;

  typedef logic [DECODE_REQUIRE_W-1:0] decode_require_t;

  // Smaller of two lane counts; used to clip pops to what is visible.
  function automatic logic [2:0] lane_min(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fq_lane_rotate.sv
// fq_lane_rotate -- combinational rotator between circular storage and the
// ordered lane view used by fetch_queue.
//   slots/head/rd_number -> rd_lanes : lane i = slots[head+i] for i < rd_number, else 0
//   tail/wr_number/wr_lanes -> wr_en/wr_slots : slot s takes lane (s-tail) when
//                                               that lane is below wr_number
module fq_lane_rotate
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  parameter int WIDTH = FQ_LANES
) (
  input  logic [DEPTH-1:0][DECODE_REQUIRE_W-1:0] slots,
  input  logic [$clog2(DEPTH)-1:0]               head,
  input  logic [2:0]                             rd_number,
  output logic [WIDTH-1:0][DECODE_REQUIRE_W-1:0] rd_lanes,
  input  logic [$clog2(DEPTH)-1:0]               tail,
  input  logic [2:0]                             wr_number,
  input  logic [WIDTH-1:0][DECODE_REQUIRE_W-1:0] wr_lanes,
  output logic [DEPTH-1:0]                       wr_en,
  output logic [DEPTH-1:0][DECODE_REQUIRE_W-1:0] wr_slots
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(WIDTH);

  // Read side: pointer arithmetic in PW bits wraps modulo DEPTH for free.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    rd_lanes = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (3'(i) < rd_number) rd_lanes[i] = slots[head + PW'(i)];
    end
  end

  // Write side: each slot works out which lane (if any) lands on it, so a
  // packet straddling the end of storage splits across the wrap per lane.
  logic [PW-1:0] off;
  always_comb begin
    off      = '0;
    wr_en    = '0;
    wr_slots = '0;
    for (int s = 0; s < DEPTH; s++) begin
      off         = PW'(s) - tail;
      wr_en[s]    = (32'(off) < 32'(wr_number));
      wr_slots[s] = wr_lanes[off[LW-1:0]];
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue -- circular instruction buffer between fetch and decode.
// Absorbs a four-wide fetch packet, releases 0..4 entries per cycle to decode,
// and discards everything on flash (branch redirect).
//   clk, rst_n   : clock, asynchronous active-low reset
//   flash        : drop all entries (beats push and pop)
//   push_data    : fetch packet, lane 0 oldest; push_number valid lanes (0..4)
//   pop_number   : entries decode consumes this cycle (clipped to out_number)
//   out_data     : oldest four entries, lane 0 oldest, invalid lanes zero
//   out_number   : min(count, 4); size_left : DEPTH - count
//   overflow     : sticky, set when a packet is rejected for lack of space
// Optional macro FETCH_QUEUE_STAT_EN adds saturating 32-bit counters
//   stat_full_cycles, stat_empty_cycles, stat_reject_pushes.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  parameter int WIDTH = FQ_LANES
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flash,
  input  logic [WIDTH-1:0][DECODE_REQUIRE_W-1:0] push_data,
  input  logic [2:0]                             push_number,
  input  logic [2:0]                             pop_number,
  output logic [WIDTH-1:0][DECODE_REQUIRE_W-1:0] out_data,
  output logic [2:0]                             out_number,
  output logic [$clog2(DEPTH):0]                 size_left,
  output logic                                   overflow
`ifdef FETCH_QUEUE_STAT_EN
  ,
  output logic [31:0]                            stat_full_cycles,
  output logic [31:0]                            stat_empty_cycles,
  output logic [31:0]                            stat_reject_pushes
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [DEPTH-1:0][DECODE_REQUIRE_W-1:0] mem;

  logic [2:0]       pop_eff, push_acc, wr_number;
  logic             reject;
  logic [DEPTH-1:0] wr_en;
  logic [DEPTH-1:0][DECODE_REQUIRE_W-1:0] wr_slots;

  // Outputs depend only on registered state; no push_data bypass.
  assign out_number = (count >= CW'(WIDTH)) ? 3'(WIDTH) : 3'(count);
  assign size_left  = CW'(DEPTH) - count;

  // Space is judged on start-of-cycle size_left; a same-cycle pop does not help.
  assign pop_eff   = lane_min(pop_number, out_number);
  assign reject    = !flash && (CW'(push_number) > size_left);
  assign push_acc  = (CW'(push_number) <= size_left) ? push_number : 3'd0;
  assign wr_number = flash ? 3'd0 : push_acc;

  fq_lane_rotate #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rotate (
    .slots     (mem),
    .head      (head),
    .rd_number (out_number),
    .rd_lanes  (out_data),
    .tail      (tail),
    .wr_number (wr_number),
    .wr_lanes  (push_data),
    .wr_en     (wr_en),
    .wr_slots  (wr_slots)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flash) begin
      // overflow is sticky across redirects.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      head  <= head + PW'(pop_eff);
      tail  <= tail + PW'(push_acc);
      count <= count + CW'(push_acc) - CW'(pop_eff);
      if (reject) overflow <= 1'b1;
    end
  end

  // NOTE: entry storage has no reset; validity comes from count alone, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    for (int s = 0; s < DEPTH; s++) begin
      if (wr_en[s]) mem[s] <= wr_slots[s];
    end
  end

`ifdef FETCH_QUEUE_STAT_EN
  // Performance counters survive flash and saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_full_cycles   <= '0;
      stat_empty_cycles  <= '0;
      stat_reject_pushes <= '0;
    end else begin
      if (count == CW'(DEPTH) && stat_full_cycles != '1)
        stat_full_cycles <= stat_full_cycles + 32'd1;
      if (count == '0 && stat_empty_cycles != '1)
        stat_empty_cycles <= stat_empty_cycles + 32'd1;
      if (reject && stat_reject_pushes != '1)
        stat_reject_pushes <= stat_reject_pushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- self-checking bench for fetch_queue (DEPTH 8, WIDTH 4).
// Table-driven directed vectors, hand sequences for wrap and async reset, then
// random traffic against a queue-based reference model. Define
// FETCH_QUEUE_STAT_EN for both bench and RTL to also check the counters.
module tb_fetch_queue;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flash = 1'b0;
  logic [3:0][31:0]  push_data = '0;
  logic [2:0]        push_number = '0;
  logic [2:0]        pop_number = '0;
  logic [3:0][31:0]  out_data;
  logic [2:0]        out_number;
  logic [3:0]        size_left;
  logic              overflow;
`ifdef FETCH_QUEUE_STAT_EN
  logic [31:0] stat_full_cycles, stat_empty_cycles, stat_reject_pushes;
`endif

  fetch_queue #(.DEPTH(8), .WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flash       (flash),
    .push_data   (push_data),
    .push_number (push_number),
    .pop_number  (pop_number),
    .out_data    (out_data),
    .out_number  (out_number),
    .size_left   (size_left),
    .overflow    (overflow)
`ifdef FETCH_QUEUE_STAT_EN
    ,
    .stat_full_cycles   (stat_full_cycles),
    .stat_empty_cycles  (stat_empty_cycles),
    .stat_reject_pushes (stat_reject_pushes)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: a plain FIFO of entries plus a sticky flag.
  logic [31:0] mq[$];
  bit          m_ovf;
  int          m_full, m_empty, m_rej;

  function automatic void model_reset();
    mq.delete();
    m_ovf = 0; m_full = 0; m_empty = 0; m_rej = 0;
  endfunction

  function automatic void model_step(int pn, logic [3:0][31:0] pd, int pp, bit fl);
    int sz, vis, pe;
    sz = mq.size();
    if (sz == 8) m_full++;
    if (sz == 0) m_empty++;
    if (fl) begin
      mq.delete();
      return;
    end
    vis = (sz < 4) ? sz : 4;
    pe  = (pp < vis) ? pp : vis;
    for (int k = 0; k < pe; k++) void'(mq.pop_front());
    if (pn <= 8 - sz) begin
      for (int k = 0; k < pn; k++) mq.push_back(pd[k]);
    end else begin
      m_ovf = 1;
      m_rej++;
    end
  endfunction

  function automatic logic [31:0] dval(int v, int l);
    return 32'h1000_0000 | (32'(v) << 8) | 32'(l);
  endfunction

  function automatic logic [3:0][31:0] packet(int v);
    logic [3:0][31:0] p;
    for (int l = 0; l < 4; l++) p[l] = dval(v, l);
    return p;
  endfunction

  // One clock: drive, edge, update model, settle 1 time unit past the edge.
  task automatic cycle(input int pn, input logic [3:0][31:0] pd, input int pp, input bit fl);
    push_number = 3'(pn);
    push_data   = pd;
    pop_number  = 3'(pp);
    flash       = fl;
    @(posedge clk);
    model_step(pn, pd, pp, fl);
    #1;
    push_number = '0;
    pop_number  = '0;
    flash       = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int sz;
    logic [31:0] exp_l;
    sz = mq.size();
    check({tag, ".out_number"}, 32'(out_number), 32'((sz < 4) ? sz : 4));
    check({tag, ".size_left"}, 32'(size_left), 32'(8 - sz));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    for (int l = 0; l < 4; l++) begin
      exp_l = (l < sz) ? mq[l] : 32'h0;
      check($sformatf("%s.lane%0d", tag, l), out_data[l], exp_l);
    end
  endtask

  typedef struct {
    int          pn;
    int          pp;
    bit          fl;
    int          exp_num;
    int          exp_left;
    bit          exp_ovf;
    logic [31:0] exp_lane0;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // Hand-derived expectations, applied from reset; packet of vector v uses dval(v, lane).
    vecs[0] = '{4, 0, 0, 4, 4, 0, dval(0, 0)};   // push A-D
    vecs[1] = '{0, 0, 0, 4, 4, 0, dval(0, 0)};   // idle, lanes hold
    vecs[2] = '{0, 2, 0, 2, 6, 0, dval(0, 2)};   // pop 2 -> C, D visible
    vecs[3] = '{4, 0, 0, 4, 2, 0, dval(0, 2)};   // count 6
    vecs[4] = '{2, 0, 0, 4, 0, 0, dval(0, 2)};   // full
    vecs[5] = '{1, 4, 0, 4, 4, 1, dval(3, 2)};   // full: push rejected, pop proceeds
    vecs[6] = '{4, 2, 1, 0, 8, 1, 32'h0};        // flash beats push/pop, overflow held
    vecs[7] = '{2, 0, 0, 2, 6, 1, dval(7, 0)};
    vecs[8] = '{0, 4, 0, 0, 8, 1, 32'h0};        // over-pop clipped

    model_reset();
    #12;
    check("reset.out_number", 32'(out_number), 32'd0);
    check("reset.size_left", 32'(size_left), 32'd8);
    check("reset.overflow", 32'(overflow), 32'd0);
    check("reset.out_data", out_data[0] | out_data[1] | out_data[2] | out_data[3], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      cycle(vecs[v].pn, packet(v), vecs[v].pp, vecs[v].fl);
      check($sformatf("vec%0d.out_number", v), 32'(out_number), 32'(vecs[v].exp_num));
      check($sformatf("vec%0d.size_left", v), 32'(size_left), 32'(vecs[v].exp_left));
      check($sformatf("vec%0d.overflow", v), 32'(overflow), 32'(vecs[v].exp_ovf));
      check($sformatf("vec%0d.lane0", v), out_data[0], vecs[v].exp_lane0);
      if (v == 2) begin
        check("vec2.lane1", out_data[1], dval(0, 3));
        check("vec2.lane2", out_data[2], 32'h0);
      end
      if (v == 6) check("vec6.lane1", out_data[1], 32'h0);
    end

`ifdef FETCH_QUEUE_STAT_EN
    // Empty after vec8's edge; the counter sees it from the following edge.
    check("stat.empty_before", stat_empty_cycles, 32'(m_empty));
    cycle(0, '0, 0, 0);
    check("stat.empty_after", stat_empty_cycles, 32'(m_empty));
    check("stat.full", stat_full_cycles, 32'(m_full));
    check("stat.reject", stat_reject_pushes, 32'(m_rej));
`endif

    // Async reset mid-operation: contents and overflow drop before any edge.
    cycle(3, packet(20), 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst.out_number", 32'(out_number), 32'd0);
    check("async_rst.size_left", 32'(size_left), 32'd8);
    check("async_rst.overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Wrap: bring head = tail = 6 with count 0, then a 4-lane push spans 6,7,0,1.
    cycle(4, packet(30), 0, 0);
    cycle(2, packet(31), 0, 0);
    cycle(0, '0, 4, 0);
    cycle(0, '0, 4, 0);
    check_model("wrap.drained");
    cycle(4, packet(32), 0, 0);
    check("wrap.lane0", out_data[0], dval(32, 0));
    check("wrap.lane1", out_data[1], dval(32, 1));
    check("wrap.lane2", out_data[2], dval(32, 2));
    check("wrap.lane3", out_data[3], dval(32, 3));
    check_model("wrap.model");

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [3:0][31:0] pd;
      for (int l = 0; l < 4; l++) pd[l] = $urandom;
      cycle($urandom_range(0, 4), pd, $urandom_range(0, 4), ($urandom_range(0, 31) == 0));
      check_model($sformatf("rand%0d", n));
    end
`ifdef FETCH_QUEUE_STAT_EN
    check("rand.stat_full", stat_full_cycles, 32'(m_full));
    check("rand.stat_empty", stat_empty_cycles, 32'(m_empty));
    check("rand.stat_reject", stat_reject_pushes, 32'(m_rej));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
